// File: rtl/rf_write_arbiter.sv
// Write-port arbiter for the RV32IM register file: WB vs. MDU with a bounded-starvation FSM.
// Optional pending-write scoreboard is built when RF_ARB_SCOREBOARD_EN is defined.
//
// state | meaning
// IDLE  | no MDU result waiting, WB has priority
// WAIT  | MDU result blocked by WB, starvation counter running
// FORCE | WB stalled for one cycle, MDU owns the write port
module rf_write_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_wen,
   input  logic [4:0]  wb_rd_addr,
   input  logic [31:0] wb_rd_data,
   output logic        wb_stall,
   input  logic        mdu_valid,
   input  logic [4:0]  mdu_rd_addr,
   input  logic [31:0] mdu_rd_data,
   output logic        mdu_ready,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd_addr,
   output logic        issue_waw,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   input  logic [4:0]  id_rd_addr,
   output logic        rs1_busy,
   output logic        rs2_busy,
   output logic        id_rd_busy,
   output logic        rf_wen,
   output logic [4:0]  rf_rd_addr,
   output logic [31:0] rf_rd_data
);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, FORCE = 2'd2} state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       wb_stall_q, wb_stall_d;
   logic       wb_req, force_act, wb_grant, mdu_grant, mdu_blocked;

   always_comb begin
      wb_req      = wb_wen && (wb_rd_addr != 5'd0);
      force_act   = (state_q == FORCE);
      wb_grant    = !rst && wb_req && !force_act;
      mdu_grant   = !rst && mdu_valid && (!wb_req || force_act);
      mdu_blocked = mdu_valid && !mdu_grant;
   end

   assign mdu_ready = mdu_grant;
   assign wb_stall  = wb_stall_q;

   // An MDU result for x0 is consumed here but never reaches the register file.
   always_comb begin
      rf_wen     = 1'b0;
      rf_rd_addr = '0;
      rf_rd_data = '0;
      if (wb_grant) begin
         rf_wen     = 1'b1;
         rf_rd_addr = wb_rd_addr;
         rf_rd_data = wb_rd_data;
      end else if (mdu_grant && (mdu_rd_addr != 5'd0)) begin
         rf_wen     = 1'b1;
         rf_rd_addr = mdu_rd_addr;
         rf_rd_data = mdu_rd_data;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (!mdu_blocked) begin
         cnt_d = '0;
      end else if (cnt_q != 4'hF) begin
         cnt_d = cnt_q + 4'd1;
      end

      state_d = state_q;
      case (state_q)
         IDLE, WAIT: begin
            if (!mdu_blocked) begin
               state_d = IDLE;
            end else if (cnt_d >= LIMIT) begin
               state_d = FORCE;
            end else begin
               state_d = WAIT;
            end
         end
         FORCE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      wb_stall_d = (state_d == FORCE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         wb_stall_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wb_stall_q <= wb_stall_d;
      end
   end

`ifdef RF_ARB_SCOREBOARD_EN
   logic [31:0] pending_q, pending_d;

   // Issue is applied after commit so a same-cycle set of the same rd wins.
   always_comb begin
      pending_d = pending_q;
      if (mdu_grant) begin
         pending_d[mdu_rd_addr] = 1'b0;
      end
      if (issue_valid) begin
         pending_d[issue_rd_addr] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   always_comb begin
      rs1_busy   = !rst && (rs1_addr != 5'd0) && pending_q[rs1_addr];
      rs2_busy   = !rst && (rs2_addr != 5'd0) && pending_q[rs2_addr];
      id_rd_busy = !rst && (id_rd_addr != 5'd0) && pending_q[id_rd_addr];
      issue_waw  = !rst && pending_q[issue_rd_addr];
   end
`else
   logic unused_sb_inputs;
   assign unused_sb_inputs = ^{issue_valid, issue_rd_addr, rs1_addr, rs2_addr, id_rd_addr};

   assign rs1_busy   = 1'b0;
   assign rs2_busy   = 1'b0;
   assign id_rd_busy = 1'b0;
   assign issue_waw  = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of arbitration, starvation and scoreboard.
module tb_rf_write_arbiter;

   localparam int LIMIT = 4;
`ifdef RF_ARB_SCOREBOARD_EN
   localparam bit SB_EN = 1'b1;
`else
   localparam bit SB_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_wen;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_rd_data;
   logic        wb_stall;
   logic        mdu_valid;
   logic [4:0]  mdu_rd_addr;
   logic [31:0] mdu_rd_data;
   logic        mdu_ready;
   logic        issue_valid;
   logic [4:0]  issue_rd_addr;
   logic        issue_waw;
   logic [4:0]  rs1_addr, rs2_addr, id_rd_addr;
   logic        rs1_busy, rs2_busy, id_rd_busy;
   logic        rf_wen;
   logic [4:0]  rf_rd_addr;
   logic [31:0] rf_rd_data;

   always #5 clk = ~clk;

   rf_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .wb_wen(wb_wen), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data), .wb_stall(wb_stall),
      .mdu_valid(mdu_valid), .mdu_rd_addr(mdu_rd_addr), .mdu_rd_data(mdu_rd_data),
      .mdu_ready(mdu_ready),
      .issue_valid(issue_valid), .issue_rd_addr(issue_rd_addr), .issue_waw(issue_waw),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .id_rd_addr(id_rd_addr),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .id_rd_busy(id_rd_busy),
      .rf_wen(rf_wen), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: this cycle is a forced cycle, length of the current blocked run, pending set.
   bit m_force;
   int m_run;
   bit m_pend [32];

   logic        e_ready, e_wen, e_stall, e_b1, e_b2, e_b3, e_waw, e_dcare;
   logic [4:0]  e_addr;
   logic [31:0] e_data;

   task automatic predict();
      bit wb_req;
      wb_req  = wb_wen && (wb_rd_addr != 5'd0);
      e_stall = m_force;
      e_ready = !rst && mdu_valid && (!wb_req || m_force);
      e_wen   = 1'b0;
      e_addr  = 5'd0;
      e_data  = 32'd0;
      e_dcare = 1'b1;
      if (!rst && wb_req && !m_force) begin
         e_wen  = 1'b1;
         e_addr = wb_rd_addr;
         e_data = wb_rd_data;
      end else if (e_ready) begin
         e_wen   = (mdu_rd_addr != 5'd0);
         e_addr  = mdu_rd_addr;
         e_data  = mdu_rd_data;
         e_dcare = (mdu_rd_addr != 5'd0);
      end
      e_b1  = SB_EN && !rst && (rs1_addr != 5'd0) && m_pend[rs1_addr];
      e_b2  = SB_EN && !rst && (rs2_addr != 5'd0) && m_pend[rs2_addr];
      e_b3  = SB_EN && !rst && (id_rd_addr != 5'd0) && m_pend[id_rd_addr];
      e_waw = SB_EN && !rst && (issue_rd_addr != 5'd0) && m_pend[issue_rd_addr];
   endtask

   task automatic advance();
      predict();
      if (rst) begin
         m_force = 1'b0;
         m_run   = 0;
         foreach (m_pend[i]) m_pend[i] = 1'b0;
      end else begin
         if (mdu_valid && !e_ready) begin
            if (m_run < 15) m_run++;
            m_force = (m_run >= LIMIT);
         end else begin
            m_run   = 0;
            m_force = 1'b0;
         end
         if (e_ready && mdu_rd_addr != 5'd0) m_pend[mdu_rd_addr] = 1'b0;
         if (issue_valid && issue_rd_addr != 5'd0) m_pend[issue_rd_addr] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wb_wen = 1'b0; wb_rd_addr = 5'd0; wb_rd_data = 32'd0;
      mdu_valid = 1'b0; mdu_rd_addr = 5'd0; mdu_rd_data = 32'd0;
      issue_valid = 1'b0; issue_rd_addr = 5'd0;
      rs1_addr = 5'd0; rs2_addr = 5'd0; id_rd_addr = 5'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      wb_wen = 1'b1; wb_rd_addr = 5'd5; wb_rd_data = 32'h1;
      mdu_valid = 1'b1; mdu_rd_addr = 5'd3;
      @(negedge clk);
      n_cmp++; if (wb_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", wb_stall); end
      n_cmp++; if (mdu_ready !== 1'b0) begin n_bad++; $display("FAIL reset_mdu_ready got %b want 0", mdu_ready); end
      n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL reset_rf_wen got %b want 0", rf_wen); end
      advance();
      rst = 1'b0;
      idle_inputs();
      @(negedge clk);
      n_cmp++; if (wb_stall !== 1'b0) begin n_bad++; $display("FAIL post_reset_stall got %b want 0", wb_stall); end
      advance();
   endtask

   task automatic test_wb_write();
      idle_inputs();
      wb_wen = 1'b1; wb_rd_addr = 5'd5; wb_rd_data = 32'h0000_1234;
      @(negedge clk);
      n_cmp++; if (rf_wen !== 1'b1) begin n_bad++; $display("FAIL wb_wen got %b want 1", rf_wen); end
      n_cmp++; if (rf_rd_addr !== 5'd5) begin n_bad++; $display("FAIL wb_addr got %0d want 5", rf_rd_addr); end
      n_cmp++; if (rf_rd_data !== 32'h0000_1234) begin n_bad++; $display("FAIL wb_data got %h want 00001234", rf_rd_data); end
      advance();
      wb_rd_addr = 5'd0; wb_rd_data = 32'h55;
      @(negedge clk);
      n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL wb_x0_wen got %b want 0", rf_wen); end
      n_cmp++; if ({rf_rd_addr, rf_rd_data} !== 37'd0) begin n_bad++; $display("FAIL wb_x0_addr_data got %0d/%h want 0/0", rf_rd_addr, rf_rd_data); end
      advance();
   endtask

   task automatic test_conflict();
      idle_inputs();
      wb_wen = 1'b1; wb_rd_addr = 5'd3; wb_rd_data = 32'hA;
      mdu_valid = 1'b1; mdu_rd_addr = 5'd7; mdu_rd_data = 32'hB;
      @(negedge clk);
      n_cmp++; if (rf_rd_addr !== 5'd3 || rf_rd_data !== 32'hA) begin n_bad++; $display("FAIL conflict_wb_wins got %0d/%h want 3/a", rf_rd_addr, rf_rd_data); end
      n_cmp++; if (mdu_ready !== 1'b0) begin n_bad++; $display("FAIL conflict_mdu_ready got %b want 0", mdu_ready); end
      advance();
      wb_wen = 1'b0;
      @(negedge clk);
      n_cmp++; if (mdu_ready !== 1'b1) begin n_bad++; $display("FAIL conflict_grant got %b want 1", mdu_ready); end
      n_cmp++; if (rf_wen !== 1'b1 || rf_rd_addr !== 5'd7 || rf_rd_data !== 32'hB) begin n_bad++; $display("FAIL conflict_mdu_write got %b/%0d/%h want 1/7/b", rf_wen, rf_rd_addr, rf_rd_data); end
      advance();
   endtask

   // Runs straight after test_conflict's grant cycle, so an uncleared counter forces early.
   task automatic test_starvation();
      logic [31:0] md;
      md = $urandom;
      for (int c = 0; c <= LIMIT; c++) begin
         wb_wen = 1'b1; wb_rd_addr = 5'($urandom_range(1, 31)); wb_rd_data = $urandom;
         mdu_valid = 1'b1; mdu_rd_addr = 5'd12; mdu_rd_data = md;
         @(negedge clk);
         if (c < LIMIT) begin
            n_cmp++; if (mdu_ready !== 1'b0 || wb_stall !== 1'b0) begin n_bad++; $display("FAIL starve_blocked c=%0d got ready=%b stall=%b want 0/0", c, mdu_ready, wb_stall); end
            n_cmp++; if (rf_rd_addr !== wb_rd_addr) begin n_bad++; $display("FAIL starve_wb_addr c=%0d got %0d want %0d", c, rf_rd_addr, wb_rd_addr); end
         end else begin
            n_cmp++; if (wb_stall !== 1'b1 || mdu_ready !== 1'b1) begin n_bad++; $display("FAIL starve_force got stall=%b ready=%b want 1/1", wb_stall, mdu_ready); end
            n_cmp++; if (rf_wen !== 1'b1 || rf_rd_addr !== 5'd12 || rf_rd_data !== md) begin n_bad++; $display("FAIL starve_mdu_write got %b/%0d/%h want 1/12/%h", rf_wen, rf_rd_addr, rf_rd_data, md); end
         end
         advance();
      end
      mdu_valid = 1'b0;
      wb_rd_addr = 5'd6; wb_rd_data = 32'h66;
      @(negedge clk);
      n_cmp++; if (wb_stall !== 1'b0 || rf_rd_addr !== 5'd6) begin n_bad++; $display("FAIL starve_release got stall=%b addr=%0d want 0/6", wb_stall, rf_rd_addr); end
      advance();
      idle_inputs();
      advance();
   endtask

   task automatic test_scoreboard();
      idle_inputs();
      issue_valid = 1'b1; issue_rd_addr = 5'd10;
      @(negedge clk);
      n_cmp++; if (issue_waw !== 1'b0) begin n_bad++; $display("FAIL sb_waw_before got %b want 0", issue_waw); end
      advance();
      issue_valid = 1'b0; rs1_addr = 5'd10; rs2_addr = 5'd0; id_rd_addr = 5'd10;
      @(negedge clk);
      n_cmp++; if (rs1_busy !== SB_EN || id_rd_busy !== SB_EN) begin n_bad++; $display("FAIL sb_busy_set got %b/%b want %b", rs1_busy, id_rd_busy, SB_EN); end
      n_cmp++; if (issue_waw !== SB_EN) begin n_bad++; $display("FAIL sb_waw got %b want %b", issue_waw, SB_EN); end
      n_cmp++; if (rs2_busy !== 1'b0) begin n_bad++; $display("FAIL sb_x0_busy got %b want 0", rs2_busy); end
      advance();
      mdu_valid = 1'b1; mdu_rd_addr = 5'd10; mdu_rd_data = 32'hC0DE;
      @(negedge clk);
      n_cmp++; if (mdu_ready !== 1'b1 || rs1_busy !== SB_EN) begin n_bad++; $display("FAIL sb_commit_cycle got ready=%b busy=%b want 1/%b", mdu_ready, rs1_busy, SB_EN); end
      advance();
      mdu_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (rs1_busy !== 1'b0 || issue_waw !== 1'b0) begin n_bad++; $display("FAIL sb_cleared got %b/%b want 0/0", rs1_busy, issue_waw); end
      advance();
      issue_valid = 1'b1;
      advance();
      mdu_valid = 1'b1;
      advance();
      issue_valid = 1'b0; mdu_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (rs1_busy !== SB_EN) begin n_bad++; $display("FAIL sb_set_wins got %b want %b", rs1_busy, SB_EN); end
      advance();
      mdu_valid = 1'b1;
      advance();
      mdu_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (rs1_busy !== 1'b0) begin n_bad++; $display("FAIL sb_final_clear got %b want 0", rs1_busy); end
      advance();
   endtask

   task automatic test_reset_mid_force();
      idle_inputs();
      rs1_addr = 5'd4; rs2_addr = 5'd9;
      for (int c = 0; c <= LIMIT; c++) begin
         wb_wen = 1'b1; wb_rd_addr = 5'(c + 1); wb_rd_data = 32'(c);
         mdu_valid = 1'b1; mdu_rd_addr = 5'd20; mdu_rd_data = 32'hF00D;
         issue_valid = (c < 2);
         issue_rd_addr = (c == 0) ? 5'd4 : 5'd9;
         if (c == LIMIT) rst = 1'b1;
         @(negedge clk);
         if (c == LIMIT - 1) begin
            n_cmp++; if (rs1_busy !== SB_EN || rs2_busy !== SB_EN) begin n_bad++; $display("FAIL rmf_pending got %b/%b want %b", rs1_busy, rs2_busy, SB_EN); end
         end
         if (c == LIMIT) begin
            n_cmp++; if (wb_stall !== 1'b1) begin n_bad++; $display("FAIL rmf_in_force got %b want 1", wb_stall); end
            n_cmp++; if (mdu_ready !== 1'b0 || rf_wen !== 1'b0 || rs1_busy !== 1'b0) begin n_bad++; $display("FAIL rmf_rst_gating got %b/%b/%b want 0/0/0", mdu_ready, rf_wen, rs1_busy); end
         end
         advance();
      end
      rst = 1'b0;
      issue_valid = 1'b0;
      for (int c = 0; c < LIMIT; c++) begin
         @(negedge clk);
         n_cmp++; if (wb_stall !== 1'b0 || mdu_ready !== 1'b0) begin n_bad++; $display("FAIL rmf_idle c=%0d got stall=%b ready=%b want 0/0", c, wb_stall, mdu_ready); end
         if (c == 0) begin
            n_cmp++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin n_bad++; $display("FAIL rmf_pending_cleared got %b/%b want 0/0", rs1_busy, rs2_busy); end
         end
         advance();
      end
      idle_inputs();
      advance();
      advance();
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         rst           = ($urandom_range(0, 63) == 0);
         wb_wen        = ($urandom_range(0, 4) != 0);
         wb_rd_addr    = 5'($urandom_range(0, 7));
         wb_rd_data    = $urandom;
         mdu_valid     = ($urandom_range(0, 2) != 0);
         mdu_rd_addr   = 5'($urandom_range(0, 7));
         mdu_rd_data   = $urandom;
         issue_valid   = ($urandom_range(0, 2) == 0);
         issue_rd_addr = 5'($urandom_range(0, 7));
         rs1_addr      = 5'($urandom_range(0, 7));
         rs2_addr      = 5'($urandom_range(0, 7));
         id_rd_addr    = 5'($urandom_range(0, 7));
         @(negedge clk);
         predict();
         n_cmp++;
         if ({mdu_ready, rf_wen, rf_rd_addr, wb_stall, rs1_busy, rs2_busy, id_rd_busy, issue_waw}
             !== {e_ready, e_wen, e_addr, e_stall, e_b1, e_b2, e_b3, e_waw}) begin
            n_bad++;
            $display("FAIL rand_ctrl n=%0d got rdy=%b wen=%b a=%0d st=%b b=%b%b%b waw=%b want rdy=%b wen=%b a=%0d st=%b b=%b%b%b waw=%b",
                     n, mdu_ready, rf_wen, rf_rd_addr, wb_stall, rs1_busy, rs2_busy, id_rd_busy, issue_waw,
                     e_ready, e_wen, e_addr, e_stall, e_b1, e_b2, e_b3, e_waw);
         end
         if (e_dcare) begin
            n_cmp++;
            if (rf_rd_data !== e_data) begin n_bad++; $display("FAIL rand_data n=%0d got %h want %h", n, rf_rd_data, e_data); end
         end
         advance();
      end
      rst = 1'b0;
      idle_inputs();
      advance();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      m_force = 1'b0;
      m_run   = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_wb_write();
      test_conflict();
      test_starvation();
      test_scoreboard();
      test_reset_mid_force();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Controller for the single write port of the 32×32 integer register file in the RV32IM core. It arbitrates that port between the in-order pipeline writeback stage and the multi-cycle MUL/DIV unit (MDU). It bounds MDU starvation with a counter-driven stall FSM. It keeps a pending-write scoreboard so the hazard unit can stall readers of registers whose MDU result has not yet landed.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive blocked MDU cycles tolerated before WB is forcibly stalled. Legal range 1..15.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `wb_wen`  in  1  WB stage write request.
- `wb_rd_addr`  in  5  WB destination.
- `wb_rd_data`  in  32  WB write data.
- `wb_stall`  out  1  registered. When 1, WB stage must hold its contents and re-present them next cycle.
- `mdu_valid`  in  1  MDU result available.
- `mdu_rd_addr`  in  5  MDU destination.
- `mdu_rd_data`  in  32  MDU result.
- `mdu_ready`  out  1  combinational grant. A transfer occurs when `mdu_valid && mdu_ready`.
- `issue_valid`  in  1  MDU op issued this cycle.
- `issue_rd_addr`  in  5  destination of the issued MDU op.
- `issue_waw`  out  1  `pending[issue_rd_addr]`; the issue logic must not issue while this is 1.
- `rs1_addr`, `rs2_addr`, `id_rd_addr`  in  5 each  decode-stage query addresses.
- `rs1_busy`, `rs2_busy`, `id_rd_busy`  out  1 each  pending bit of the queried register; always 0 for x0.
- `rf_wen`  out  1  register file write enable.
- `rf_rd_addr`  out  5  register file write address.
- `rf_rd_data`  out  32  register file write data.

## Operation
- Requests:
  - WB requests when `wb_wen && wb_rd_addr != 0`. A write to x0 is a non-request and is never forwarded.
  - MDU requests when `mdu_valid`. An MDU result for x0 is accepted and dropped, with `rf_wen` = 0.
- Arbitration:
  - WB has priority unless the FSM is in FORCE.
  - `mdu_ready = mdu_valid && (!wb_req || state==FORCE)`.
  - In FORCE the WB request is ignored; the pipeline re-presents it next cycle.
- Write mux:
  - The winner drives `rf_*`.
  - If neither side is granted, `rf_wen` = 0 and address/data are 0.
- FSM states:
  - IDLE → WAIT when `mdu_valid && !mdu_ready`.
  - WAIT → IDLE on grant or when `mdu_valid` drops.
  - WAIT → FORCE when the blocked count reaches STARVE_LIMIT.
  - FORCE → IDLE unconditionally after 1 cycle.
  - `wb_stall` = 1 exactly while in FORCE.
- Starvation counter, 4 bits:
  - +1 on each cycle with `mdu_valid && !mdu_ready`.
  - Cleared on grant or `!mdu_valid`.
  - Saturates, with no wrap.
- Scoreboard, `pending[31:1]`:
  - Set on `issue_valid && issue_rd_addr != 0`.
  - Cleared on an MDU transfer to that rd.
  - Set and clear of the same rd in the same cycle: set wins.
  - Re-issue to an already pending rd is idempotent.
  - Busy outputs reflect the registered bits only, with no same-cycle bypass of a committing write.

## Timing
- Reset values, applied on the clock edge with `rst`=1:
  - state = IDLE, counter = 0, `wb_stall` = 0, `pending` = 0.
  - While `rst` is high, `mdu_ready`, `rf_wen` and all busy outputs are forced to 0.
- Write path from `wb_*`/`mdu_*` to `rf_*` is combinational (0 latency); the register file captures at the next edge.
- Starvation: with WB requesting every cycle, the MDU is blocked for STARVE_LIMIT cycles, FORCE occurs on cycle STARVE_LIMIT, and the MDU is granted in that cycle.
- Busy: a pending bit set at edge N is visible from cycle N onward. After commit at edge M, busy reads 0 from cycle M.
- Reset mid-FORCE or mid-WAIT: the next cycle is IDLE and all pending bits are cleared. In-flight MDU state is the MDU's responsibility.

## Configuration
- `RF_ARB_SCOREBOARD_EN` defined: scoreboard built as described.
- `RF_ARB_SCOREBOARD_EN` undefined:
  - No pending flops.
  - All `*_busy` outputs and `issue_waw` are tied to 0.
  - `issue_*` inputs are ignored.
  - Arbitration and the FSM are unchanged. This build is for cores whose MDU blocks the pipeline until completion.

## Test plan
- WB alone, `wb_wen`=1, rd=5, data=0x00001234 → same cycle `rf_wen`=1, `rf_rd_addr`=5, `rf_rd_data`=0x00001234. With rd=0 → `rf_wen`=0.
- Conflict: WB rd=3 data=0xA and MDU rd=7 data=0xB in the same cycle → `rf_rd_addr`=3 and `mdu_ready`=0. Next cycle with WB idle → `mdu_ready`=1, write x7=0xB, counter back to 0.
- Starvation, STARVE_LIMIT=4, WB requesting every cycle, `mdu_valid` held → `mdu_ready`=0 for cycles 0–3. Cycle 4: `wb_stall`=1, `mdu_ready`=1, MDU write. Cycle 5: `wb_stall`=0.
- Scoreboard:
  - Issue rd=10 → next cycle `rs1_addr`=10 gives `rs1_busy`=1 and `issue_waw`=1 for rd=10.
  - MDU commit rd=10 → busy 0 the following cycle.
  - `rs2_addr`=0 → never busy.
- Simultaneous issue rd=10 and MDU commit rd=10 → `pending[10]` remains 1.
- Assert `rst` for 1 cycle during FORCE with pending bits x4 and x9 set → next cycle `wb_stall`=0, all busy 0, state IDLE. In a build without `RF_ARB_SCOREBOARD_EN`, repeating the scoreboard scenario yields busy=0 throughout.
